// File: rtl/nsu_noc2axi_pack_rx.sv
// NoC-side receiver: checks head/tail codes, destination and flit count, and releases only complete packets.
// Optional NSU_RX_ERR_CNT_EN adds err_cnt (saturating drop counter) and err_cnt_clr.
module nsu_noc2axi_pack_rx #(
  parameter int                       DATA_WIDTH     = 128,
  parameter int                       ID_WIDTH       = 4,
  parameter int                       VIRTUAL_CH_NUM = 16,
  parameter int                       AXI_ADDR_WIDTH = 32,
  parameter int                       BUF_ADDR_WIDTH = 5,
  parameter logic [ID_WIDTH-1:0]      LOCAL_ID       = 4'h0,
  parameter int                       HEAD_CODE_BIT  = 4,
  parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_H    = 4'hA,
  parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_E    = 4'hB,
  parameter int                       TAIL_CODE_BIT  = 4,
  parameter logic [TAIL_CODE_BIT-1:0] TAIL_CODE_H    = 4'hC,
  parameter logic [TAIL_CODE_BIT-1:0] TAIL_CODE_E    = 4'hD
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic [DATA_WIDTH:0]   nocdata,
  input  logic                  s_is_head,
  input  logic                  s_is_tail,
  output logic                  nsu_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  pkt_drop
`ifdef NSU_RX_ERR_CNT_EN
  ,
  input  logic                  err_cnt_clr,
  output logic [15:0]           err_cnt
`endif
);

  localparam int DEPTH      = 2 ** BUF_ADDR_WIDTH;
  localparam int PW         = BUF_ADDR_WIDTH + 1;
  localparam int CODE_H_LSB = DATA_WIDTH - HEAD_CODE_BIT;
  localparam int DST_LSB    = DATA_WIDTH - HEAD_CODE_BIT - 2 * ID_WIDTH;
  localparam int LEN_LSB    = DST_LSB - 3 - VIRTUAL_CH_NUM - 8;
  localparam int CODE_E_LSB = DATA_WIDTH - 2 * HEAD_CODE_BIT - 2 * ID_WIDTH - 11
                              - VIRTUAL_CH_NUM - AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [8:0]        body_cnt_q, body_cnt_d;
  logic [7:0]        len_q, len_d;
  logic              nsu_ready_q, nsu_ready_d;
  logic              pkt_drop_q;

  logic [DATA_WIDTH+1:0] buf_mem [DEPTH];
  logic [DATA_WIDTH+1:0] rd_word;

  logic                  flit_vld, is_head, is_tail, is_body;
  logic [DATA_WIDTH-1:0] flit;
  logic                  head_codes_ok, tail_codes_ok, dst_ok;
  logic                  full, full_commit, rd_fire;
  logic                  drop, wr_en, wr_sop, wr_eop;
  logic [PW-1:0]         wr_addr;

  assign flit_vld = nocdata[DATA_WIDTH];
  assign flit     = nocdata[DATA_WIDTH-1:0];
  assign is_head  = flit_vld & s_is_head;
  assign is_tail  = flit_vld & s_is_tail;
  assign is_body  = flit_vld & ~s_is_head & ~s_is_tail;

  assign head_codes_ok = (flit[CODE_H_LSB +: HEAD_CODE_BIT] == HEAD_CODE_H) &&
                         (flit[CODE_E_LSB +: HEAD_CODE_BIT] == HEAD_CODE_E);
  assign tail_codes_ok = (flit[CODE_H_LSB +: TAIL_CODE_BIT] == TAIL_CODE_H) &&
                         (flit[CODE_E_LSB +: TAIL_CODE_BIT] == TAIL_CODE_E);
  assign dst_ok        = (flit[DST_LSB +: ID_WIDTH] == LOCAL_ID);

  // full_commit is the occupancy seen by a head, which always restarts from the commit point
  assign full        = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign full_commit = (commit_ptr_q - rd_ptr_q) == PW'(DEPTH);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    body_cnt_d   = body_cnt_q;
    len_d        = len_q;
    drop         = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;
    wr_sop       = 1'b0;
    wr_eop       = 1'b0;
    case (state_q)
      IDLE, BODY: begin
        if (is_head) begin
          wr_ptr_d = commit_ptr_q;
          state_d  = IDLE;
          if (state_q == BODY) drop = 1'b1;
          if (s_is_tail) begin
            drop = 1'b1;
          end else if (!head_codes_ok || !dst_ok || full_commit) begin
            drop    = 1'b1;
            state_d = DROP;
          end else begin
            wr_en      = 1'b1;
            wr_addr    = commit_ptr_q;
            wr_sop     = 1'b1;
            wr_ptr_d   = commit_ptr_q + 1'b1;
            body_cnt_d = '0;
            len_d      = flit[LEN_LSB +: 8];
            state_d    = BODY;
          end
        end else if (state_q == IDLE) begin
          if (flit_vld) drop = 1'b1;
        end else if (is_tail) begin
          state_d = IDLE;
          if (!full && tail_codes_ok && (body_cnt_q == ({1'b0, len_q} + 9'd1))) begin
            wr_en        = 1'b1;
            wr_eop       = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            commit_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            drop     = 1'b1;
            wr_ptr_d = commit_ptr_q;
          end
        end else if (is_body) begin
          if (full) begin
            drop     = 1'b1;
            wr_ptr_d = commit_ptr_q;
            state_d  = DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (body_cnt_q != 9'h1FF) body_cnt_d = body_cnt_q + 9'd1;
          end
        end
      end
      DROP: begin
        if (is_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read side is first-word fall-through and never passes the commit pointer
  assign rd_word     = buf_mem[rd_ptr_q[BUF_ADDR_WIDTH-1:0]];
  assign m_valid     = (rd_ptr_q != commit_ptr_q);
  assign m_data      = m_valid ? rd_word[DATA_WIDTH-1:0] : '0;
  assign m_sop       = m_valid & rd_word[DATA_WIDTH+1];
  assign m_eop       = m_valid & rd_word[DATA_WIDTH];
  assign rd_fire     = m_valid & m_ready;
  assign rd_ptr_d    = rd_ptr_q + {{BUF_ADDR_WIDTH{1'b0}}, rd_fire};
  assign nsu_ready_d = ~((wr_ptr_d - rd_ptr_d) == PW'(DEPTH));
  assign nsu_ready   = nsu_ready_q;
  assign pkt_drop    = pkt_drop_q;

  always_ff @(posedge noc_clk) begin
    if (wr_en) buf_mem[wr_addr[BUF_ADDR_WIDTH-1:0]] <= {wr_sop, wr_eop, flit};
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      body_cnt_q   <= '0;
      len_q        <= '0;
      nsu_ready_q  <= 1'b1;
      pkt_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      body_cnt_q   <= body_cnt_d;
      len_q        <= len_d;
      nsu_ready_q  <= nsu_ready_d;
      pkt_drop_q   <= drop;
    end
  end

`ifdef NSU_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) err_cnt_d = '0;
    else if (drop && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) err_cnt_q <= '0;
    else            err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_nsu_noc2axi_pack_rx.sv
// Self-checking bench for nsu_noc2axi_pack_rx: packet vector table plus hand-written corner sequences,
// with delivered beats checked against a scoreboard queue.
module tb_nsu_noc2axi_pack_rx;

  localparam int DW  = 128;
  localparam int BAW = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    logic [3:0] dst;
    logic [3:0] head_code_e;
    logic [3:0] tail_code_h;
    logic [7:0] len;
    int         n_body;
    bit         single;
    bit         exp_deliver;
    int         exp_drops;
  } vec_t;

  logic          noc_clk;
  logic          noc_rst_n;
  logic [DW:0]   nocdata;
  logic          s_is_head;
  logic          s_is_tail;
  logic          nsu_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sop;
  logic          m_eop;
  logic          pkt_drop;
`ifdef NSU_RX_ERR_CNT_EN
  logic          err_cnt_clr;
  logic [15:0]   err_cnt;
`endif

  int    n_compares    = 0;
  int    n_miscompares = 0;
  int    drop_seen     = 0;
  beat_t exp_q[$];
  beat_t mon_beat;
  vec_t  vecs[10];

  nsu_noc2axi_pack_rx #(.BUF_ADDR_WIDTH(BAW)) dut (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .nocdata   (nocdata),
    .s_is_head (s_is_head),
    .s_is_tail (s_is_tail),
    .nsu_ready (nsu_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .pkt_drop  (pkt_drop)
`ifdef NSU_RX_ERR_CNT_EN
    ,
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt)
`endif
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic checkOutput(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_compares++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {129'b0, act}, {129'b0, exp});
  endtask

  // Monitor: counts drop pulses and checks every accepted beat against the scoreboard
  always @(negedge noc_clk) begin
    if (noc_rst_n) begin
      if (pkt_drop) drop_seen++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_compares++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_beat: got %h with nothing expected", m_data);
        end else begin
          mon_beat = exp_q.pop_front();
          checkOutput("beat", {m_sop, m_eop, m_data}, {mon_beat.sop, mon_beat.eop, mon_beat.data});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] makeHead(input logic [3:0] code_e, input logic [3:0] dst,
                                             input logic [7:0] len);
    logic [DW-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[127:124] = 4'hA;
    f[123:120] = 4'h3;
    f[119:116] = dst;
    f[96:89]   = len;
    f[56:53]   = code_e;
    return f;
  endfunction

  function automatic logic [DW-1:0] makeTail(input logic [3:0] code_h);
    logic [DW-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[127:124] = code_h;
    f[56:53]   = 4'hD;
    return f;
  endfunction

  task automatic driveFlit(input logic [DW-1:0] f, input logic h, input logic t);
    nocdata   = {1'b1, f};
    s_is_head = h;
    s_is_tail = t;
    @(posedge noc_clk);
    #1;
    nocdata   = '0;
    s_is_head = 1'b0;
    s_is_tail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || m_valid) && cyc < 300) begin
      @(posedge noc_clk);
      #1;
      cyc++;
    end
    checkOutput(name, 130'(exp_q.size()), 130'(0));
  endtask

  // Builds a packet (head, n body, tail), optionally queues it as expected output, then drives it
  task automatic sendPacket(input logic [3:0] dst, input logic [3:0] head_code_e,
                            input logic [3:0] tail_code_h, input logic [7:0] len,
                            input int n_body, input bit deliver);
    logic [DW-1:0] flits[$];
    beat_t b;
    flits.push_back(makeHead(head_code_e, dst, len));
    for (int k = 0; k < n_body; k++) flits.push_back({$urandom, $urandom, $urandom, $urandom});
    flits.push_back(makeTail(tail_code_h));
    if (deliver) begin
      for (int k = 0; k < flits.size(); k++) begin
        b.data = flits[k];
        b.sop  = (k == 0);
        b.eop  = (k == flits.size() - 1);
        exp_q.push_back(b);
      end
    end
    for (int k = 0; k < flits.size(); k++) driveFlit(flits[k], k == 0, k == flits.size() - 1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int drops0;
    drops0 = drop_seen;
    if (v.single) driveFlit(makeHead(v.head_code_e, v.dst, v.len), 1'b1, 1'b1);
    else sendPacket(v.dst, v.head_code_e, v.tail_code_h, v.len, v.n_body, v.exp_deliver);
    idle(3);
    waitDrain($sformatf("v%0d_drain", idx));
    checkOutput($sformatf("v%0d_drops", idx), 130'(drop_seen - drops0), 130'(v.exp_drops));
    checkBit($sformatf("v%0d_m_valid_idle", idx), m_valid, 1'b0);
  endtask

  initial begin
    int drops0;

    //          dst   code_e tail_h len   nb single deliver drops
    vecs[0] = '{4'h0, 4'hB, 4'hC, 8'd1, 2, 1'b0, 1'b1, 0};
    vecs[1] = '{4'h0, 4'hE, 4'hC, 8'd1, 2, 1'b0, 1'b0, 1};
    vecs[2] = '{4'h0, 4'hB, 4'hC, 8'd0, 1, 1'b0, 1'b1, 0};
    vecs[3] = '{4'h0, 4'hB, 4'hC, 8'd2, 2, 1'b0, 1'b0, 1};
    vecs[4] = '{4'h5, 4'hB, 4'hC, 8'd1, 2, 1'b0, 1'b0, 1};
    vecs[5] = '{4'h0, 4'hB, 4'hE, 8'd1, 2, 1'b0, 1'b0, 1};
    vecs[6] = '{4'h0, 4'hB, 4'hC, 8'd0, 2, 1'b0, 1'b0, 1};
    vecs[7] = '{4'h0, 4'hB, 4'hC, 8'd3, 4, 1'b0, 1'b1, 0};
    vecs[8] = '{4'h0, 4'hB, 4'hC, 8'd0, 0, 1'b1, 1'b0, 1};
    vecs[9] = '{4'h0, 4'hB, 4'hC, 8'd2, 3, 1'b0, 1'b1, 0};

    noc_rst_n = 1'b0;
    nocdata   = '0;
    s_is_head = 1'b0;
    s_is_tail = 1'b0;
    m_ready   = 1'b1;
`ifdef NSU_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    idle(3);
    checkBit("rst_m_valid", m_valid, 1'b0);
    checkBit("rst_m_sop", m_sop, 1'b0);
    checkBit("rst_m_eop", m_eop, 1'b0);
    checkBit("rst_pkt_drop", pkt_drop, 1'b0);
    checkBit("rst_nsu_ready", nsu_ready, 1'b1);
    checkOutput("rst_m_data", {2'b0, m_data}, 130'(0));
    noc_rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Stray tail while idle
    drops0 = drop_seen;
    driveFlit(makeTail(4'hC), 1'b0, 1'b1);
    idle(3);
    checkOutput("stray_tail_drops", 130'(drop_seen - drops0), 130'(1));
    checkBit("stray_tail_m_valid", m_valid, 1'b0);

    // Overflow: 9-flit packet into an 8-deep buffer, then an 8-flit packet held until commit
    m_ready = 1'b0;
    drops0  = drop_seen;
    driveFlit(makeHead(4'hB, 4'h0, 8'd6), 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) driveFlit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    checkBit("ovf_nsu_ready_full", nsu_ready, 1'b0);
    driveFlit(makeTail(4'hC), 1'b0, 1'b1);
    idle(3);
    checkOutput("ovf_drops", 130'(drop_seen - drops0), 130'(1));
    checkBit("ovf_m_valid", m_valid, 1'b0);
    checkBit("ovf_nsu_ready_after", nsu_ready, 1'b1);
    sendPacket(4'h0, 4'hB, 4'hC, 8'd5, 6, 1'b1);
    idle(1);
    checkBit("fit8_m_valid", m_valid, 1'b1);
    checkBit("fit8_m_sop", m_sop, 1'b1);
    checkBit("fit8_nsu_ready", nsu_ready, 1'b0);
    m_ready = 1'b1;
    waitDrain("fit8_drain");
    checkOutput("fit8_drops", 130'(drop_seen - drops0), 130'(1));

    // Head arriving mid-body abandons the first packet
    drops0 = drop_seen;
    driveFlit(makeHead(4'hB, 4'h0, 8'd1), 1'b1, 1'b0);
    driveFlit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    sendPacket(4'h0, 4'hB, 4'hC, 8'd1, 2, 1'b1);
    idle(3);
    waitDrain("midhead_drain");
    checkOutput("midhead_drops", 130'(drop_seen - drops0), 130'(1));

    // Reset mid-packet with a committed packet still waiting
    m_ready = 1'b0;
    sendPacket(4'h0, 4'hB, 4'hC, 8'd0, 1, 1'b0);
    idle(1);
    checkBit("prerst_m_valid", m_valid, 1'b1);
    driveFlit(makeHead(4'hB, 4'h0, 8'd1), 1'b1, 1'b0);
    driveFlit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    #3;
    noc_rst_n = 1'b0;
    #1;
    checkBit("midrst_m_valid", m_valid, 1'b0);
    checkBit("midrst_nsu_ready", nsu_ready, 1'b1);
    checkOutput("midrst_m_data", {2'b0, m_data}, 130'(0));
    idle(1);
    noc_rst_n = 1'b1;
    m_ready   = 1'b1;
    idle(1);
    drops0 = drop_seen;
    sendPacket(4'h0, 4'hB, 4'hC, 8'd2, 3, 1'b1);
    idle(3);
    waitDrain("postrst_drain");
    checkOutput("postrst_drops", 130'(drop_seen - drops0), 130'(0));

`ifdef NSU_RX_ERR_CNT_EN
    checkOutput("err_cnt_base", 130'(err_cnt), 130'(0));
    for (int k = 0; k < 3; k++) driveFlit(makeTail(4'hC), 1'b0, 1'b1);
    idle(2);
    checkOutput("err_cnt_three", 130'(err_cnt), 130'(3));
    err_cnt_clr = 1'b1;
    driveFlit(makeTail(4'hC), 1'b0, 1'b1);
    err_cnt_clr = 1'b0;
    checkOutput("err_cnt_clr_wins", 130'(err_cnt), 130'(0));
    idle(2);
    checkOutput("err_cnt_after_clr", 130'(err_cnt), 130'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_compares, n_miscompares);
    $finish;
  end

endmodule
